// File: rtl/txfifo_wr_arb.sv
// Packet-granular round-robin write arbiter for the TX FIFO: admits a whole
// packet only when the FIFO has room for it, then streams it without interleaving.
module txfifo_wr_arb #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 256,
    parameter int DEPTH = 1024,
    parameter int PTR   = 10
) (
    input  logic                       clk,
    input  logic                       reset_,
    input  logic [NREQ-1:0]            req_i,
    input  logic [NREQ*(PTR+1)-1:0]    len_i,
    input  logic [NREQ-1:0]            vld_i,
    input  logic [NREQ*WIDTH-1:0]      data_i,
    input  logic [NREQ-1:0]            eop_i,
    output logic [NREQ-1:0]            rdy_o,
    output logic [NREQ-1:0]            gnt_o,
    output logic                       busy_o,
    output logic                       len_err_o,
    output logic                       fifo_wrreq,
    output logic [WIDTH-1:0]           fifo_data,
    input  logic [PTR:0]               fifo_wrusedw,
    input  logic                       fifo_wrfull
);

    localparam int           IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PTR:0] DEPTH_W = (PTR+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, XFER, SETTLE} state_t;

    state_t            state_reg, state_next;
    logic [IW-1:0]     rr_ptr_reg, rr_ptr_next;
    logic [IW-1:0]     g_idx_reg, g_idx_next;
    logic [NREQ-1:0]   gnt_reg, gnt_next;
    logic [PTR:0]      len_reg, len_next;
    logic [PTR:0]      cnt_reg, cnt_next;
    logic              len_err_reg, len_err_next;
    logic              busy_reg, busy_next;

    logic [PTR:0]      len_arr  [NREQ];
    logic [WIDTH-1:0]  data_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign len_arr[gi]  = len_i[gi*(PTR+1) +: (PTR+1)];
            assign data_arr[gi] = data_i[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // First pending requester at or after rr_ptr, wrapping modulo NREQ.
    logic          cand_found;
    logic [IW-1:0] cand_idx;
    int            scan;

    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        scan       = 0;
        for (int i = 0; i < NREQ; i++) begin
            scan = int'(rr_ptr_reg) + i;
            if (scan >= NREQ) begin
                scan = scan - NREQ;
            end
            if (!cand_found && req_i[IW'(scan)]) begin
                cand_found = 1'b1;
                cand_idx   = IW'(scan);
            end
        end
    end

    logic [PTR:0]  cand_len;
    logic [PTR:0]  space;
    logic          len_bad;
    logic [IW-1:0] ptr_inc;
    logic          accept;
    logic          eop_sel;
    logic          cnt_last;

    assign cand_len = len_arr[cand_idx];
    assign len_bad  = (cand_len == '0) || (cand_len > DEPTH_W);
    assign space    = (fifo_wrusedw > DEPTH_W) ? '0 : (DEPTH_W - fifo_wrusedw);
    assign ptr_inc  = (cand_idx == IW'(NREQ-1)) ? '0 : (cand_idx + 1'b1);

    assign accept   = (state_reg == XFER) && vld_i[g_idx_reg] && !fifo_wrfull;
    assign eop_sel  = eop_i[g_idx_reg];
    assign cnt_last = (cnt_reg == (len_reg - 1'b1));

    always_comb begin
        state_next   = state_reg;
        rr_ptr_next  = rr_ptr_reg;
        g_idx_next   = g_idx_reg;
        gnt_next     = gnt_reg;
        len_next     = len_reg;
        cnt_next     = cnt_reg;
        len_err_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cand_found) begin
                    if (len_bad) begin
                        len_err_next = 1'b1;
                        rr_ptr_next  = ptr_inc;
                    end else if (space >= cand_len) begin
                        len_next    = cand_len;
                        cnt_next    = '0;
                        gnt_next    = {{(NREQ-1){1'b0}}, 1'b1} << cand_idx;
                        g_idx_next  = cand_idx;
                        rr_ptr_next = ptr_inc;
                        state_next  = XFER;
                    end
                end
            end
            XFER: begin
                if (accept) begin
                    cnt_next = cnt_reg + 1'b1;
                    // Stop at whichever comes first so the admitted space is never overrun.
                    if (eop_sel || cnt_last) begin
                        len_err_next = (eop_sel != cnt_last);
                        gnt_next     = '0;
                        state_next   = SETTLE;
                    end
                end
            end
            SETTLE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_reg   <= IDLE;
            rr_ptr_reg  <= '0;
            g_idx_reg   <= '0;
            gnt_reg     <= '0;
            len_reg     <= '0;
            cnt_reg     <= '0;
            len_err_reg <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            rr_ptr_reg  <= rr_ptr_next;
            g_idx_reg   <= g_idx_next;
            gnt_reg     <= gnt_next;
            len_reg     <= len_next;
            cnt_reg     <= cnt_next;
            len_err_reg <= len_err_next;
            busy_reg    <= busy_next;
        end
    end

    assign rdy_o      = gnt_reg & {NREQ{accept}};
    assign fifo_wrreq = accept;
    assign fifo_data  = data_arr[g_idx_reg];
    assign gnt_o      = gnt_reg;
    assign busy_o     = busy_reg;
    assign len_err_o  = len_err_reg;

endmodule

// File: doc/txfifo_wr_arb.md
# txfifo_wr_arb

Packet-granular write arbiter for the 1024x256 TX FIFO. It shares the single FIFO write port between NREQ upstream packet sources using round-robin order. It admits a packet only when the FIFO has room for the whole packet, then streams the packet's 256-bit words into the FIFO without interleaving. It sits between the host-side TX packet builders and the TX FIFO write side, in the same clock domain as the FIFO write clock.

## Interface
Parameters:
- NREQ, 2: number of requesters (2..4).
- WIDTH, 256: data word width.
- DEPTH, 1024: FIFO depth in words.
- PTR, 10: log2(DEPTH).

Ports:
- clk  in  1  single clock; same as the FIFO write clock.
- reset_  in  1  asynchronous, active-low reset.
- req_i  in  NREQ  per-requester packet pending; held until the requester's last word is accepted.
- len_i  in  NREQ*(PTR+1)  packet length in words. Slice i belongs to requester i. Stable while req_i[i]=1.
- vld_i  in  NREQ  data word valid.
- data_i  in  NREQ*WIDTH  data word. Slice i belongs to requester i.
- eop_i  in  NREQ  marks the last word of the packet.
- rdy_o  out  NREQ  word accepted this cycle (one-hot or zero).
- gnt_o  out  NREQ  registered one-hot grant, held for the whole packet.
- busy_o  out  1  a packet transfer is in progress.
- len_err_o  out  1  one-cycle pulse on a length/eop mismatch or an illegal length.
- fifo_wrreq  out  1  write strobe to the FIFO.
- fifo_data  out  WIDTH  write data to the FIFO.
- fifo_wrusedw  in  PTR+1  FIFO fill level in words.
- fifo_wrfull  in  1  FIFO full flag.

## Operation
- **States:** IDLE, XFER, SETTLE.
- **Reset:** state=IDLE, rr_ptr=0, gnt_o=0, rdy_o=0, busy_o=0, len_err_o=0, fifo_wrreq=0, word counter=0.
- **IDLE, candidate selection:** the candidate is the first index with req_i set, scanning from rr_ptr upward modulo NREQ.
- **IDLE, illegal length:** applies when len=0 or len>DEPTH. Pulse len_err_o, set rr_ptr=cand+1, stay in IDLE, and grant nothing.
- **IDLE, grant:** applies when DEPTH - fifo_wrusedw >= len. Latch len, set gnt_o[cand], clear the word counter, set rr_ptr=cand+1 mod NREQ, and go to XFER.
- **IDLE, no room:** wait in IDLE. Do not skip to another requester (strict round-robin, no head-of-line bypass), so large packets are never starved.
- **XFER, acceptance:** a word is accepted when vld_i[g] & ~fifo_wrfull.
  - Acceptance drives fifo_wrreq=1, rdy_o[g]=1, and increments the counter.
  - fifo_data = data_i[g] combinationally. When no word is accepted, fifo_data is don't-care.
- **XFER, packet end:** the packet ends on the first accepted word where eop_i[g]=1 or count == len-1.
  - If these two conditions disagree on that word, pulse len_err_o in the following cycle.
  - The transfer never exceeds the latched len, so the space guarantee holds.
- **XFER exit:** on the end word, go to SETTLE and clear gnt_o.
- **SETTLE:** lasts one cycle so that fifo_wrusedw reflects the last write. Then go to IDLE.
- **Width rules:**
  - Space is computed as (PTR+1)-bit unsigned DEPTH - fifo_wrusedw. fifo_wrusedw > DEPTH is treated as zero space.
  - The word counter is PTR+1 bits.
- **Reset mid-packet:** the transfer is abandoned immediately and all outputs return to reset values. Partial-packet cleanup is handled by resetting the FIFO concurrently.

## Timing
- Grant latency: req_i sampled in IDLE at cycle t produces gnt_o=1 and state XFER at t+1. The first word can be written at t+1.
- Throughput inside a packet: 1 word per cycle while vld_i and ~fifo_wrfull hold.
- Minimum gap between packets: the last word at cycle n leads to SETTLE at n+1, IDLE at n+2, and the next gnt_o at n+3. That is 2 idle write cycles.
- rdy_o and fifo_wrreq are combinational from vld_i[g], fifo_wrfull, and the registered state/gnt.
- gnt_o, busy_o, and len_err_o are registered.
- Simultaneous requests are resolved by rr_ptr only. A requester whose req_i rises while another packet is in XFER waits for SETTLE→IDLE.

## Test plan
- **Single packet:** reset; req0 with len=4 and 4 consecutive vld words, eop on word 4. Expect gnt_o=01 one cycle later, 4 fifo_wrreq pulses carrying data in order, len_err_o=0, and busy_o low 2 cycles after the last word.
- **Round-robin fairness:** req0 and req1 both held with len=2 each for 3 packets. Expect the grant order 0,1,0,1,0,1 and no interleaving of words within a packet.
- **Space check:** fifo_wrusedw=1020, req0 len=8. Expect no grant. Drop fifo_wrusedw to 1016; expect a grant on the next cycle. Also confirm req1 (len=1) is not granted while req0 waits.
- **Backpressure:** assert fifo_wrfull mid-packet for 3 cycles and toggle vld_i. Expect fifo_wrreq=rdy_o=0 during those cycles and all len words eventually written exactly once.
- **Length errors:**
  - len=4 with eop on word 2: expect the packet to end after 2 words and a len_err_o pulse.
  - len=3 with no eop: expect 3 words written and a len_err_o pulse.
  - len=0: expect an immediate len_err_o, no grant, and rr_ptr advanced.
- **Reset mid-packet:** assert reset_ low during word 3 of a len=10 packet. Expect all outputs 0 asynchronously, and after release a fresh grant starting with rr_ptr=0.
